// File: rtl/mdu_sequencer_pkg.sv
// rtl/mdu_sequencer_pkg.sv - shared types, constants and result helpers for the RV32M sequencer
//
// Contents:
//   XLEN, ITER_COUNT   operand width and number of iterative steps
//   mdu_op_e           RV32M funct3 encoding
//   mdu_state_e        sequencer state encoding
//   neg_if, mul_fix    sign fix-up helpers shared by the fast and iterative paths
package mdu_sequencer_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    // Products are formed on magnitudes; restore the sign, then pick the half the op wants.
    function automatic logic [XLEN-1:0] mul_fix(input mdu_op_e f3, input logic neg,
                                                input logic [2*XLEN-1:0] mag_prod);
        logic [2*XLEN-1:0] p;
        p = neg ? -mag_prod : mag_prod;
        return (f3 == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - radix-2 restoring unsigned divider, one quotient bit per step
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   load_i                   capture dividend/divisor, clear partial remainder
//   step_i                   perform one restoring iteration
//   dividend_i, divisor_i    unsigned magnitudes
//   quotient_o, remainder_o  valid after ITER_COUNT steps
module mdu_div_core
    import mdu_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [XLEN:0]   shifted, diff;

    // The dividend is shifted out of quo_q's top while quotient bits enter at the bottom.
    // rem_q < dvs_q always holds, so bit XLEN of diff is a reliable borrow flag.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - RV32M multiply/divide sequencer (IDLE/BUSY/DONE)
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start, op      request and RV32M funct3, sampled on acceptance (IDLE or DONE, no flush)
//   rs1, rs2       operands, captured on acceptance
//   flush          abort; forces IDLE next cycle and wins over start
//   busy           high in BUSY
//   stall          combinational freeze: BUSY, or a multi-cycle op being accepted
//   valid, result  one-cycle completion pulse; result holds until the next completion
//
// Build option: MDU_FAST_MUL_EN makes MUL* single-cycle; otherwise they take the
// 32-step shift-add path with the same timing as divide.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            valid,
    output logic [XLEN-1:0] result
);
    import mdu_sequencer_pkg::*;

    mdu_state_e      state_q;
    mdu_op_e         op_q;
    logic [5:0]      count_q;
    logic            neg_q, rneg_q, valid_q, iter_q;
    logic [XLEN-1:0] result_q, mul_a_q, mul_hi_q, mul_lo_q;

    mdu_op_e         op_e;
    logic            signed_a, signed_b, a_neg, b_neg;
    logic            div_zero, div_ovf, fast_mul, quick, accept;
    logic [XLEN-1:0] mag_a, mag_b, quick_result, iter_result, div_quo, div_rem;
    logic [XLEN:0]   mul_sum;

    assign op_e = mdu_op_e'(op);

    always_comb begin
        signed_a = (op_e == OP_DIV) || (op_e == OP_REM) || (op_e == OP_MULH) || (op_e == OP_MULHSU);
        signed_b = (op_e == OP_DIV) || (op_e == OP_REM) || (op_e == OP_MULH);
        a_neg    = signed_a && rs1[XLEN-1];
        b_neg    = signed_b && rs2[XLEN-1];
        mag_a    = neg_if(a_neg, rs1);
        mag_b    = neg_if(b_neg, rs2);
        div_zero = op[2] && (rs2 == '0);
        div_ovf  = signed_b && op[2] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
`ifdef MDU_FAST_MUL_EN
        fast_mul = !op[2];
`else
        fast_mul = 1'b0;
`endif
        quick_result = '0;
        if (div_zero) begin
            quick_result = op[1] ? rs1 : '1;
        end else if (div_ovf) begin
            quick_result = op[1] ? '0 : rs1;
        end
`ifdef MDU_FAST_MUL_EN
        else begin
            quick_result = mul_fix(op_e, a_neg ^ b_neg, {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b});
        end
`endif
    end

    assign quick  = div_zero || div_ovf || fast_mul;
    assign accept = start && !flush && (state_q != ST_BUSY);
    assign stall  = reset_n && ((state_q == ST_BUSY) || (accept && !quick));
    assign busy   = (state_q == ST_BUSY);
    assign valid  = valid_q;

    // Shift-add multiplier: add multiplicand into the high half when the multiplier LSB is set,
    // then shift the whole {hi, lo} pair right; the multiplier drains out of lo as the product fills in.
    assign mul_sum = {1'b0, mul_hi_q} + (mul_lo_q[0] ? {1'b0, mul_a_q} : '0);

    mdu_div_core u_div_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (accept && !quick),
        .step_i      (state_q == ST_BUSY),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        case (op_q)
            OP_DIV, OP_DIVU: iter_result = neg_if(neg_q, div_quo);
            OP_REM, OP_REMU: iter_result = neg_if(rneg_q, div_rem);
            default:         iter_result = mul_fix(op_q, neg_q, {mul_hi_q, mul_lo_q});
        endcase
    end

    // The last iteration lands on the same edge that enters DONE, so an iterative result is
    // presented straight from the datapath during DONE and latched into result_q on leaving it.
    assign result = (state_q == ST_DONE && iter_q) ? iter_result : result_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            count_q  <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            valid_q  <= 1'b0;
            iter_q   <= 1'b0;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_hi_q <= '0;
            mul_lo_q <= '0;
        end else begin
            valid_q <= 1'b0;
            iter_q  <= 1'b0;
            if (state_q == ST_DONE && iter_q) begin
                result_q <= iter_result;
            end
            if (flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_BUSY: begin
                        count_q              <= count_q + 6'd1;
                        {mul_hi_q, mul_lo_q} <= {mul_sum, mul_lo_q[XLEN-1:1]};
                        if (count_q == 6'(ITER_COUNT - 1)) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                            iter_q  <= 1'b1;
                        end
                    end
                    default: begin
                        if (start) begin
                            op_q   <= op_e;
                            neg_q  <= a_neg ^ b_neg;
                            rneg_q <= a_neg;
                            if (quick) begin
                                state_q  <= ST_DONE;
                                valid_q  <= 1'b1;
                                result_q <= quick_result;
                            end else begin
                                state_q  <= ST_BUSY;
                                count_q  <= '0;
                                mul_a_q  <= mag_a;
                                mul_hi_q <= '0;
                                mul_lo_q <= mag_b;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (only 32 supported).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request from EX stage; sampled when accepted (REQ-011).
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports rs1, rs2  input  XLEN  operands, captured on acceptance.
REQ-007 SHALL have port flush  input  1  abort from hazard/branch unit.
REQ-008 SHALL have port busy  output  1  high in BUSY state.
REQ-009 SHALL have port stall  output  1  combinational pipeline freeze.
REQ-010 SHALL have ports valid  output  1 and result  output  XLEN  completion pulse and result.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE; start is accepted in IDLE or DONE when flush is low.
REQ-012 Accepted divide ops (no special case) SHALL go to BUSY for exactly 32 cycles (radix-2 restoring, 6-bit counter), then DONE; valid is high in the cycle 33 cycles after acceptance.
REQ-013 Divide by zero SHALL skip BUSY and go directly to DONE (valid 1 cycle after acceptance): DIV/DIVU = 0xFFFFFFFF, REM/REMU = rs1.
REQ-014 Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF) SHALL skip BUSY: DIV = 0x80000000, REM = 0.
REQ-015 Signed divide SHALL operate on magnitudes; quotient negated when signs differ, remainder takes sign of rs1.
REQ-016 MUL SHALL return low 32 bits of the 64-bit product; MULH/MULHSU/MULHU SHALL return the high 32 bits with operands signed/signed, signed/unsigned, and unsigned/unsigned respectively.
REQ-017 valid SHALL be high for exactly one cycle (DONE); result SHALL hold its value until the next completion.
REQ-018 stall SHALL equal (state==BUSY) OR (start AND NOT flush AND state in {IDLE, DONE} AND the op will not complete next cycle… i.e. it enters BUSY); stall is low in DONE unless a new multi-cycle op is accepted.
REQ-019 DONE with no new start SHALL return to IDLE; start in DONE SHALL be accepted (back-to-back, no idle bubble).
REQ-020 start while BUSY SHALL be ignored.
REQ-021 flush SHALL force IDLE next cycle from any state, suppress valid, and win over a simultaneous start.

Reset
REQ-022 While reset_n is low: state = IDLE, counter = 0, busy = 0, valid = 0, result = 0, internal operand/remainder registers = 0; stall = 0.
REQ-023 Reset asserted mid-operation SHALL abandon the operation with no valid pulse.

Configuration
REQ-024 With MDU_FAST_MUL_EN defined, MUL* ops SHALL compute in one cycle and go directly to DONE (valid 1 cycle after acceptance, stall never asserted for them).
REQ-025 Without MDU_FAST_MUL_EN, MUL* ops SHALL use a 32-iteration shift-add through BUSY, with timing identical to REQ-012.

Structure
REQ-026 A shared package SHALL hold the funct3 op enum, the state enum, and the constants XLEN and ITER_COUNT = 32.
REQ-027 The iterative divide datapath SHALL be a sub-module mdu_div_core (operands, step enable, quotient/remainder out); the FSM, sign fix-up, and special cases remain in mdu_sequencer.

Verification
REQ-028 DIVU 100/7: valid is high 33 cycles after start, with result 14; REMU gives 2; stall is high for cycles 0..32.
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-030 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each completes with valid 1 cycle after start.
REQ-031 MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; latency is 1 with the macro defined and 33 without.
REQ-032 Start DIVU, assert flush at cycle 10 -> IDLE next cycle, no valid pulse; then a start in DONE back-to-back -> second result valid 33 cycles after it; start asserted while BUSY -> ignored.
